// File: rtl/lcd_hd44780_rx_if.sv
// HD44780 parallel bus as seen between an LCD driver (master) and the emulated panel (slave).
// Combinational bundle only; no latency of its own.
// No backpressure: the master paces accesses with the E strobe and the busy flag.
interface lcd_hd44780_rx_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data_i;
  logic [7:0] lcd_data_o;
  logic       lcd_data_oe;

  modport master (
    output lcd_e, lcd_rs, lcd_rw, lcd_data_i,
    input  lcd_data_o, lcd_data_oe
  );

  modport slave (
    input  lcd_e, lcd_rs, lcd_rw, lcd_data_i,
    output lcd_data_o, lcd_data_oe
  );
endinterface

// File: rtl/lcd_hd44780_rx.sv
// HD44780 receiver emulation: 32-byte DDRAM, address counter, display-on bit, busy flag.
// State updates 3 clk_i cycles after the raw E falling edge; reads drive the bus 3 cycles after E rises.
// Writes arriving while busy are dropped and flagged on err_o; busy timing only with LCD_RX_BUSY_EN defined.
module lcd_hd44780_rx #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  lcd_hd44780_rx_if.slave     bus,
  input  logic [4:0]          rd_addr_i,
  output logic [7:0]          rd_data_o,
  output logic                disp_on_o,
  output logic                busy_o,
  output logic                err_o
);

  // synchronizers and edge history
  logic       e_s1_q, e_s2_q, e_prev_q;
  logic       rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
  logic [7:0] dat_s1_q, dat_s2_q;
  // post-reset qualification: an access is honoured only if E was seen low after reset
  logic       settled_q, settled_d, low_seen_q, low_seen_d, armed_q, armed_d;
  // values captured while synchronized E is high
  logic       lat_rs_q, lat_rs_d, lat_rw_q, lat_rw_d;
  logic [7:0] lat_dat_q, lat_dat_d;
  // architectural state
  logic [7:0] mem_q [32];
  logic [7:0] mem_d [32];
  logic [4:0] ac_q, ac_d, ac_step;
  logic       id_q, id_d, disp_q, disp_d, err_q, err_d;
  logic       oe_q, oe_d;
  logic [7:0] dout_q, dout_d;
  logic       rise, fall, busy, load_busy, load_clear;

`ifdef LCD_RX_BUSY_EN
  localparam int MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign busy = (cnt_q != '0);

  // busy down-counter: reload on an accepted command, otherwise count toward zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_clear)      cnt_d = CNT_W'(CLEAR_CYCLES);
    else if (load_busy)  cnt_d = CNT_W'(BUSY_CYCLES);
    else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // busy counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign busy = 1'b0;
  wire unused_cfg = ^{BUSY_CYCLES, CLEAR_CYCLES, load_busy, load_clear};
`endif

  assign rise    = e_s2_q & ~e_prev_q;
  assign fall    = e_prev_q & ~e_s2_q & armed_q;
  assign ac_step = id_q ? (ac_q + 5'd1) : (ac_q - 5'd1);

  // capture, decode and execute one access per synchronized E falling edge
  always_comb begin
    settled_d  = 1'b1;
    low_seen_d = low_seen_q | (settled_q & ~e_s1_q);
    armed_d    = armed_q;
    lat_rs_d   = lat_rs_q;
    lat_rw_d   = lat_rw_q;
    lat_dat_d  = lat_dat_q;
    mem_d      = mem_q;
    ac_d       = ac_q;
    id_d       = id_q;
    disp_d     = disp_q;
    err_d      = err_q;
    load_busy  = 1'b0;
    load_clear = 1'b0;

    if (rise && low_seen_q) armed_d = 1'b1;
    if (fall)               armed_d = 1'b0;

    if (e_s2_q) begin
      lat_rs_d  = rs_s2_q;
      lat_rw_d  = rw_s2_q;
      lat_dat_d = dat_s2_q;
    end

    if (fall) begin
      if (!lat_rw_q) begin
        if (busy) begin
          err_d = 1'b1;
        end else if (lat_rs_q) begin
          mem_d[ac_q] = lat_dat_q;
          ac_d        = ac_step;
          load_busy   = 1'b1;
        end else if (lat_dat_q[7]) begin
          ac_d      = {lat_dat_q[6], lat_dat_q[3:0]};
          load_busy = 1'b1;
        end else if (lat_dat_q[6] || lat_dat_q[5]) begin
          load_busy = 1'b1;
        end else if (lat_dat_q[4]) begin
          if (!lat_dat_q[3]) ac_d = lat_dat_q[2] ? (ac_q + 5'd1) : (ac_q - 5'd1);
          load_busy = 1'b1;
        end else if (lat_dat_q[3]) begin
          disp_d    = lat_dat_q[2];
          load_busy = 1'b1;
        end else if (lat_dat_q[2]) begin
          id_d      = lat_dat_q[1];
          load_busy = 1'b1;
        end else if (lat_dat_q[1]) begin
          ac_d       = 5'd0;
          load_clear = 1'b1;
        end else if (lat_dat_q[0]) begin
          for (int i = 0; i < 32; i++) mem_d[i] = 8'h20;
          ac_d       = 5'd0;
          id_d       = 1'b1;
          load_clear = 1'b1;
        end
      end else if (lat_rs_q) begin
        ac_d = ac_step;
      end
    end

    oe_d   = e_s2_q & rw_s2_q;
    dout_d = 8'h00;
    if (oe_d) dout_d = rs_s2_q ? mem_q[ac_q] : {busy, ac_q[4], 2'b00, ac_q[3:0]};
  end

  // all state registers; reset returns the panel to its power-on contents
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_s1_q <= 1'b0;  e_s2_q <= 1'b0;  e_prev_q <= 1'b0;
      rs_s1_q <= 1'b0; rs_s2_q <= 1'b0; rw_s1_q <= 1'b0; rw_s2_q <= 1'b0;
      dat_s1_q <= 8'h00; dat_s2_q <= 8'h00;
      settled_q <= 1'b0; low_seen_q <= 1'b0; armed_q <= 1'b0;
      lat_rs_q <= 1'b0; lat_rw_q <= 1'b0; lat_dat_q <= 8'h00;
      for (int i = 0; i < 32; i++) mem_q[i] <= 8'h20;
      ac_q <= 5'd0; id_q <= 1'b1; disp_q <= 1'b0; err_q <= 1'b0;
      oe_q <= 1'b0; dout_q <= 8'h00;
    end else begin
      e_s1_q <= bus.lcd_e;       e_s2_q <= e_s1_q;   e_prev_q <= e_s2_q;
      rs_s1_q <= bus.lcd_rs;     rs_s2_q <= rs_s1_q;
      rw_s1_q <= bus.lcd_rw;     rw_s2_q <= rw_s1_q;
      dat_s1_q <= bus.lcd_data_i; dat_s2_q <= dat_s1_q;
      settled_q <= settled_d; low_seen_q <= low_seen_d; armed_q <= armed_d;
      lat_rs_q <= lat_rs_d; lat_rw_q <= lat_rw_d; lat_dat_q <= lat_dat_d;
      mem_q <= mem_d;
      ac_q <= ac_d; id_q <= id_d; disp_q <= disp_d; err_q <= err_d;
      oe_q <= oe_d; dout_q <= dout_d;
    end
  end

  assign bus.lcd_data_oe = oe_q;
  assign bus.lcd_data_o  = dout_q;
  assign rd_data_o       = mem_q[rd_addr_i];
  assign disp_on_o       = disp_q;
  assign busy_o          = busy;
  assign err_o           = err_q;

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Randomized bench for lcd_hd44780_rx with a queue-based read scoreboard and a behavioural panel model.
module tb_lcd_hd44780_rx;
  localparam int BUSY  = 40;
  localparam int CLEAR = 300;
  localparam int GAP   = 60;
`ifdef LCD_RX_BUSY_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [4:0] rd_addr_i = 5'd0;
  logic [7:0] rd_data_o;
  logic       disp_on_o, busy_o, err_o;
  lcd_hd44780_rx_if bus ();

  lcd_hd44780_rx #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .disp_on_o(disp_on_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #10 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // behavioural model of the panel
  int m_mem [32];
  int m_ac, m_id, m_disp, m_err, m_busy_end;

  function automatic bit m_busy(input int t);
    return BUSY_EN && (t < m_busy_end);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h20;
    m_ac = 0; m_id = 1; m_disp = 0; m_err = 0; m_busy_end = 0;
  endfunction

  function automatic int m_next(input int a, input int up);
    return up != 0 ? (a + 1) % 32 : (a + 31) % 32;
  endfunction

  function automatic void m_write(input bit rs, input int d, input int t);
    if (m_busy(t + 2)) begin
      m_err = 1;
      return;
    end
    if (rs) begin
      m_mem[m_ac] = d;
      m_ac = m_next(m_ac, m_id);
      m_busy_end = t + 3 + BUSY;
    end else if (d >= 128) begin
      m_ac = ((d / 64) % 2) * 16 + (d % 16);
      m_busy_end = t + 3 + BUSY;
    end else if (d >= 32) begin
      m_busy_end = t + 3 + BUSY;
    end else if (d >= 16) begin
      if ((d & 8) == 0) m_ac = m_next(m_ac, (d & 4) != 0);
      m_busy_end = t + 3 + BUSY;
    end else if (d >= 8) begin
      m_disp = (d / 4) % 2;
      m_busy_end = t + 3 + BUSY;
    end else if (d >= 4) begin
      m_id = (d / 2) % 2;
      m_busy_end = t + 3 + BUSY;
    end else if (d >= 2) begin
      m_ac = 0;
      m_busy_end = t + 3 + CLEAR;
    end else if (d == 1) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h20;
      m_ac = 0; m_id = 1;
      m_busy_end = t + 3 + CLEAR;
    end
  endfunction

  // scoreboard of expected read-back bytes
  int exp_q [$];
  bit oe_prev = 1'b0;

  always @(negedge clk_i) begin
    if (bus.lcd_data_oe && !oe_prev) begin
      if (exp_q.size() == 0) chk("unexpected_read", 1, 0);
      else chk("read_data", int'(bus.lcd_data_o), exp_q.pop_front());
    end
    oe_prev = bus.lcd_data_oe;
  end

  task automatic access(input bit rs, input bit rw, input logic [7:0] d, input int gap);
    @(negedge clk_i);
    bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data_i = rw ? 8'h00 : d;
    if (rw) begin
      if (rs) exp_q.push_back(m_mem[m_ac]);
      else    exp_q.push_back({m_busy(cyc + 3), 7'(0)} | ((m_ac / 16) * 64) | (m_ac % 16));
    end
    @(negedge clk_i);
    bus.lcd_e = 1'b1;
    repeat (4) @(negedge clk_i);
    bus.lcd_e = 1'b0;
    if (!rw)     m_write(rs, int'(d), cyc);
    else if (rs) m_ac = m_next(m_ac, m_id);
    repeat (3 + gap) @(negedge clk_i);
  endtask

  task automatic check_ddram(input string name);
    for (int i = 0; i < 32; i++) begin
      rd_addr_i = 5'(i);
      #1;
      chk(name, int'(rd_data_o), m_mem[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    m_reset();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);
  endtask

  initial begin
    bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data_i = 8'h00;
    do_reset();

    chk("rst_disp", int'(disp_on_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_oe", int'(bus.lcd_data_oe), 0);
    chk("rst_dout", int'(bus.lcd_data_o), 0);
    check_ddram("rst_ddram");

    // init sequence
    access(0, 0, 8'h38, GAP);
    access(0, 0, 8'h0C, GAP);
    access(0, 0, 8'h06, GAP);
    chk("init_disp", int'(disp_on_o), m_disp);
    chk("init_err", int'(err_o), 0);
    access(0, 1, 8'h00, GAP);

    // two data bytes then BF/AC
    access(1, 0, 8'h48, GAP);
    access(1, 0, 8'h49, GAP);
    rd_addr_i = 5'd0; #1; chk("data0", int'(rd_data_o), 32'h48);
    rd_addr_i = 5'd1; #1; chk("data1", int'(rd_data_o), 32'h49);
    access(0, 1, 8'h00, GAP);

    // address 31 and wrap to 0
    access(0, 0, 8'hCF, GAP);
    access(1, 0, 8'h41, GAP);
    access(1, 0, 8'h42, GAP);
    rd_addr_i = 5'd31; #1; chk("wrap31", int'(rd_data_o), 32'h41);
    rd_addr_i = 5'd0;  #1; chk("wrap0", int'(rd_data_o), 32'h42);

    // clear: busy while long timer runs, then idle with blank DDRAM
    access(0, 0, 8'h01, 100);
    chk("clear_busy", int'(busy_o), int'(BUSY_EN));
    access(0, 1, 8'h00, 330);
    access(0, 1, 8'h00, GAP);
    check_ddram("clear_ddram");

    // data write shortly after a command
    access(0, 0, 8'h80, 10);
    access(1, 0, 8'h55, GAP);
    chk("busy_err", int'(err_o), m_err);
    rd_addr_i = 5'd0; #1; chk("busy_write", int'(rd_data_o), m_mem[0]);

    // random traffic against the model
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: access(1, 0, 8'($urandom_range(32, 126)), GAP);
        3:       access(0, 0, 8'(8'h80 | $urandom_range(0, 127)), GAP);
        4:       access(0, 0, 8'(8'h04 | $urandom_range(0, 3)), GAP);
        5:       access(1, 1, 8'h00, GAP);
        6:       access(0, 0, 8'(8'h10 | $urandom_range(0, 15)), GAP);
        default: access(0, 1, 8'h00, GAP);
      endcase
    end
    check_ddram("rand_ddram");
    chk("rand_disp", int'(disp_on_o), m_disp);
    chk("rand_err", int'(err_o), m_err);
    access(0, 1, 8'h00, GAP);

    // reset in the middle of a data write strobe
    access(0, 0, 8'h85, GAP);
    @(negedge clk_i);
    bus.lcd_rs = 1'b1; bus.lcd_rw = 1'b0; bus.lcd_data_i = 8'h77;
    @(negedge clk_i);
    bus.lcd_e = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    m_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    bus.lcd_e = 1'b0;
    repeat (3 + GAP) @(negedge clk_i);
    check_ddram("rstmid_ddram");
    chk("rstmid_err", int'(err_o), 0);
    access(0, 1, 8'h00, GAP);

    repeat (10) @(negedge clk_i);
    chk("pending_reads", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
